// File: rtl/uart_tx_8n1_if.sv
// Byte-strobe handshake and serial-line bundle between the G-code sender and the UART transmitter.
interface uart_tx_8n1_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx;
   logic       tx_done;

   modport master (output tx_valid, output tx_data, input tx_ready, input tx, input tx_done);
   modport slave  (input tx_valid, input tx_data, output tx_ready, output tx, output tx_done);
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter (1 or 2 stop bits): accepts a byte strobe while idle and
// shifts start, 8 data bits LSB first and the stop bit(s) onto a registered line.
module uart_tx_8n1 #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_8n1_if.slave  bus
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_e;

   state_e             state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_q, tx_d;
   logic               tx_ready_q, tx_ready_d;
   logic               tx_done_q, tx_done_d;
   logic               baud_last_c;

   assign baud_last_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         tx_ready_q <= tx_ready_d;
         tx_done_q  <= tx_done_d;
      end
   end

   // Next-state logic; the line level for each bit is registered one edge ahead.
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      tx_ready_d = tx_ready_q;
      tx_done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d       = 1'b1;
            tx_ready_d = 1'b1;
            if (bus.tx_valid && tx_ready_q) begin
               shift_d    = bus.tx_data;
               state_d    = ST_START;
               tx_d       = 1'b0;
               tx_ready_d = 1'b0;
               baud_d     = '0;
               bit_cnt_d  = '0;
            end
         end
         ST_START: begin
            if (baud_last_c) begin
               state_d   = ST_DATA;
               baud_d    = '0;
               bit_cnt_d = '0;
               tx_d      = shift_q[0];
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            if (baud_last_c) begin
               baud_d = '0;
               if (bit_cnt_q == CNT_W'(7)) begin
                  state_d   = ST_STOP;
                  bit_cnt_d = '0;
                  tx_d      = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  tx_d      = shift_q[bit_cnt_q + CNT_W'(1)];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (baud_last_c) begin
               baud_d = '0;
               if (bit_cnt_q == CNT_W'(STOP_BITS - 1)) begin
                  state_d    = ST_IDLE;
                  bit_cnt_d  = '0;
                  tx_ready_d = 1'b1;
                  tx_done_d  = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.tx       = tx_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.tx_done  = tx_done_q;

endmodule
